// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared constants for the RAM viewer 7-segment display
//
// Purpose: hex font table, blank pattern and digit count used by the
// display top level and the segment decoder.
package disp_pkg;

  // Number of multiplexed digits on the display.
  localparam int NDIG = 4;

  // Active-low all-segments-off pattern {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-high hex font, order {g,f,e,d,c,b,a}; entry N is HEX_FONT[N].
  localparam logic [15:0][6:0] HEX_FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39,  // F E d C
    7'h7C, 7'h77, 7'h6F, 7'h7F,  // b A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66,  // 7 6 5 4
    7'h4F, 7'h5B, 7'h06, 7'h3F   // 3 2 1 0
  };

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational hex digit to active-low 7-segment decoder
//
// Purpose: converts one 4-bit value to its segment pattern.
// Ports:
//   hex  in  [3:0]  value to display
//   seg  out [6:0]  segments {g,f,e,d,c,b,a}, active-low
module hex_to_seg7
  import disp_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // The font is stored lit-high; the display drives segments low to light.
  assign seg = ~HEX_FONT[hex];

endmodule

// File: rtl/ram_view_disp.sv
// rtl/ram_view_disp.sv - 4-digit multiplexed display of the RAM word and its history
//
// Purpose: digit 0 shows the current RAM read word, digits 1-3 the three
// previous distinct values (newest first). The digit-0 decimal point blinks
// while the RAM stage is writing.
// Ports:
//   clk    in        system clock
//   rst_n  in        asynchronous active-low reset
//   din    in  [3:0] RAM read data
//   we     in        write-enable indicator (1 = writing)
//   seg    out [6:0] segments {g,f,e,d,c,b,a}, active-low, registered
//   dp     out       decimal point, active-low, registered
//   an     out [3:0] digit anodes, active-low one-hot, registered; an[0] = digit 0
module ram_view_disp
  import disp_pkg::*;
#(
  parameter int SCAN_DIV  = 125000,
  parameter int GUARD     = 1250,
  parameter int BLINK_DIV = 31250000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      din,
  input  logic            we,
  output logic [6:0]      seg,
  output logic            dp,
  output logic [NDIG-1:0] an
);

  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int IDX_W   = $clog2(NDIG);

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [SCAN_W-1:0]  GUARD_END  = SCAN_W'(GUARD);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  // Capture / history state. vld[n] marks digit n as holding a real value.
  logic [3:0]      cur;
  logic [3:0]      hist0;
  logic [3:0]      hist1;
  logic [3:0]      hist2;
  logic [NDIG-1:0] vld;

  // Scan and blink state.
  logic [SCAN_W-1:0]  scan_cnt;
  logic [IDX_W-1:0]   idx;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_ph;

  // Next values for the output registers.
  logic [3:0]      sel_val;
  logic            sel_vld;
  logic [6:0]      seg_font;
  logic            in_guard;
  logic [6:0]      seg_d;
  logic            dp_d;
  logic [NDIG-1:0] an_d;

  // The first word after reset only fills digit 0. After that, only a
  // change of value pushes the history along, so a held word never scrolls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur   <= 4'h0;
      hist0 <= 4'h0;
      hist1 <= 4'h0;
      hist2 <= 4'h0;
      vld   <= '0;
    end else if (!vld[0]) begin
      cur    <= din;
      vld[0] <= 1'b1;
    end else if (din != cur) begin
      hist2           <= hist1;
      hist1           <= hist0;
      hist0           <= cur;
      cur             <= din;
      vld[NDIG-1:1]   <= vld[NDIG-2:0];
    end
  end

  // Digit slot timer: one slot per SCAN_DIV clocks, digits in order 0..3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      idx      <= idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Blink timer runs only while writing. Any clock with we low restarts it,
  // so every write burst begins with the decimal point dark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (!we) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_ph  <= ~blink_ph;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_comb begin
    sel_val = cur;
    sel_vld = vld[idx];
    case (idx)
      2'd0:    sel_val = cur;
      2'd1:    sel_val = hist0;
      2'd2:    sel_val = hist1;
      default: sel_val = hist2;
    endcase
  end

  hex_to_seg7 u_hex_to_seg7 (
    .hex (sel_val),
    .seg (seg_font)
  );

  // The guard keeps all anodes dark at the start of a slot while the
  // segment lines settle to the new digit, avoiding ghosting.
  always_comb begin
    in_guard = (scan_cnt < GUARD_END);
    seg_d    = sel_vld ? seg_font : SEG_BLANK;
    an_d     = in_guard ? '1 : ~({{(NDIG-1){1'b0}}, 1'b1} << idx);
    dp_d     = ~((idx == '0) && we && blink_ph && !in_guard);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_BLANK;
      dp  <= 1'b1;
      an  <= '1;
    end else begin
      seg <= seg_d;
      dp  <= dp_d;
      an  <= an_d;
    end
  end

endmodule
